cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
Transmitting end of the Common Data Bus that the reservation stations listen to. It collects completed results from the functional units (FUs), buffers them per FU, and round-robin arbitrates among them. Each cycle it broadcasts at most one registered result (RS tag + value). It sits between the FU outputs and every CDB consumer: RS, map table, and ROB.

Parameters:
NUM_FU, 5, number of FU result ports; one per RS entry/FU slot
TAG_W, 3, RS tag width
DATA_W, 32, result value width
FIFO_DEPTH, 2, result buffer depth per FU; power of two, >=2
INVALID_TAG, 7, tag driven when the bus is idle

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
fu_valid  in  NUM_FU  FU i presents a result
fu_ready  out  NUM_FU  FU i's buffer can accept a result this cycle
fu_tag  in  NUM_FU*TAG_W  packed; slice i = RS tag of FU i's result
fu_value  in  NUM_FU*DATA_W  packed; slice i = result value of FU i
cdb_valid  out  1  broadcast valid
cdb_tag  out  TAG_W  RS tag being freed/woken
cdb_value  out  DATA_W  broadcast value
cdb_fu_idx  out  $clog2(NUM_FU)  index of the FU granted for the current broadcast
pending  out  1  at least one buffered result not yet broadcast
flush  in  1  squash all buffered results (present only with CDB_FLUSH_EN)

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: cdb_valid=0, cdb_tag=INVALID_TAG, cdb_value=0, cdb_fu_idx=0, pending=0. All FIFOs empty. Round-robin pointer=0. fu_ready=all ones from the first cycle after reset.
- Accept rule:
  - fu_ready[i] = (count[i] < FIFO_DEPTH). It is purely registered state, with no combinational path from arbitration or fu_valid.
  - A result is accepted at a rising edge when fu_valid[i] && fu_ready[i].
  - fu_valid while not ready is ignored. The FU must hold its result and retry.
- Storage: per-FU circular FIFO with read pointer, write pointer and count; pointers wrap modulo FIFO_DEPTH. Push and pop on the same FIFO in the same cycle: both happen and count is unchanged. A full FIFO cannot push even if it pops that cycle.
- Arbitration:
  - Combinational each cycle over non-empty FIFOs.
  - Priority starts at the pointer ptr and wraps upward: ptr, ptr+1, ..., NUM_FU-1, 0, ...
  - At most one grant per cycle. The granted FIFO pops its head.
  - After a grant to g, ptr <= (g+1) mod NUM_FU. With no grant, ptr holds.
- Output register:
  - On a grant at edge k, cdb_valid=1, cdb_tag, cdb_value and cdb_fu_idx=g are visible for exactly one cycle after edge k.
  - With no grant: cdb_valid=0, cdb_tag=INVALID_TAG, cdb_value=0, and cdb_fu_idx holds its last value.
  - Every broadcast is one cycle only; consumers never apply backpressure.
- Latency: a result accepted at edge k is broadcast no earlier than the cycle after edge k+1 (2-edge minimum). An arriving result never bypasses the buffer.
- Ordering: results from one FU are broadcast in acceptance order. No ordering is guaranteed across FUs.
- Fairness: with all FIFOs continuously non-empty, each FU is granted exactly once per NUM_FU cycles.
- pending: registered. Equals OR of (next count[i] != 0).
- Tags are not checked. Any fu_tag value, including INVALID_TAG, is passed through unchanged.
- Reset mid-operation: buffered results are discarded. Any broadcast in flight is dropped, and cdb_valid=0 on the next cycle.

Optional Feature:
CDB_FLUSH_EN:
- When defined, the flush port exists. flush=1 at an edge:
  - all counts and pointers clear, and same-cycle pushes are dropped;
  - no grant occurs, and the output register loads the idle values (cdb_valid=0);
  - ptr holds;
  - pending=0 afterward.
- A broadcast already visible in the flush cycle completes normally.
- When undefined, the flush port and its logic are absent, and the buffers drain only by broadcast.

Test Plan:
1. Reset: assert reset 2 cycles while fu_valid=5'b11111 -> cdb_valid=0, cdb_tag=7, pending=0, fu_ready=5'b11111; no result retained.
2. Single result: FU2 pushes tag=2, value=32'hDEADBEEF at edge 0 -> after edge 1, cdb_valid=1, tag=2, value=DEADBEEF, fu_idx=2 for one cycle; then cdb_valid=0 and tag=7.
3. Round-robin: all 5 FUs push tag=i, value=100+i in one cycle, ptr=0 -> broadcasts tag order 0,1,2,3,4 on 5 consecutive cycles; pending falls with the last pop.
4. Backpressure and order: FU0 pushes values 1,2,3 on consecutive edges with FIFO_DEPTH=2 while FU1..4 stay busy -> fu_ready[0]=0 once count hits 2; value 3 is accepted only after a pop; FU0 broadcasts 1,2,3 in order.
5. Fairness under saturation: all FUs push every cycle for 50 cycles -> each FU granted 10 times; grant sequence strictly cycles 0..4; no grant gap.
6. Flush (CDB_FLUSH_EN): load FU1 and FU3 with 2 results each, assert flush for 1 cycle after the first broadcast -> no further cdb_valid, pending=0, fu_ready=5'b11111; a new FU4 push afterward broadcasts normally.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers FU results per FU and broadcasts one per cycle on the CDB, round-robin; optional flush port with CDB_FLUSH_EN
module cdb_arbiter #(
  parameter int NUM_FU      = 5,
  parameter int TAG_W       = 3,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 2,
  parameter int INVALID_TAG = 7
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_FU-1:0]          fu_valid,
  output logic [NUM_FU-1:0]          fu_ready,
  input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
  input  logic [NUM_FU*DATA_W-1:0]   fu_value,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_value,
  output logic [$clog2(NUM_FU)-1:0]  cdb_fu_idx,
  output logic                       pending
`ifdef CDB_FLUSH_EN
  ,
  input  logic                       flush
`endif
);
  localparam int IW = $clog2(NUM_FU);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = TAG_W + DATA_W;

`ifndef CDB_FLUSH_EN
  logic flush;
  assign flush = 1'b0;
`endif

  logic [EW-1:0]      mem [NUM_FU][FIFO_DEPTH];
  logic [AW-1:0]      rd_ptr [NUM_FU];
  logic [AW-1:0]      wr_ptr [NUM_FU];
  logic [AW:0]        count [NUM_FU];
  logic [AW:0]        cnt_nxt [NUM_FU];
  logic [NUM_FU-1:0]  nonempty, push, pop, nz_nxt;
  logic [IW-1:0]      ptr, gnt;
  logic [2*NUM_FU-1:0] rot;
  logic [IW:0]        off, sum;
  logic               any;

  // ready depends only on registered occupancy
  always_comb begin
    fu_ready = '0;
    nonempty = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = count[i] < (AW+1)'(FIFO_DEPTH);
      nonempty[i] = count[i] != '0;
    end
  end

  // rotate occupancy so the pointer sits at bit 0, take the lowest set bit, rotate back
  always_comb begin
    rot = {nonempty, nonempty} >> ptr;
    off = '0;
    for (int k = NUM_FU - 1; k >= 0; k--)
      if (rot[k]) off = (IW+1)'(k);
    sum = {1'b0, ptr} + off;
    gnt = sum >= (IW+1)'(NUM_FU) ? IW'(sum - (IW+1)'(NUM_FU)) : IW'(sum);
    any = |nonempty && !flush;
  end

  // per-FU push/pop and next occupancy
  always_comb begin
    push = '0;
    pop = '0;
    nz_nxt = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      push[i] = fu_valid[i] && fu_ready[i] && !flush;
      pop[i] = any && gnt == IW'(i);
      cnt_nxt[i] = count[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      nz_nxt[i] = cnt_nxt[i] != '0;
    end
  end

  // FIFO payload storage, written on accept
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= {fu_tag[i*TAG_W +: TAG_W], fu_value[i*DATA_W +: DATA_W]};
  end

  // FIFO pointers and occupancy; flush empties every buffer
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (reset || flush) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i] <= '0;
      end else begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= cnt_nxt[i];
      end
    end
  end

  // round-robin pointer, output register and pending flag
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
      cdb_valid <= 1'b0;
      cdb_tag <= TAG_W'(INVALID_TAG);
      cdb_value <= '0;
      cdb_fu_idx <= '0;
      pending <= 1'b0;
    end else begin
      pending <= flush ? 1'b0 : |nz_nxt;
      if (any) begin
        ptr <= gnt == IW'(NUM_FU - 1) ? '0 : gnt + 1'b1;
        cdb_valid <= 1'b1;
        {cdb_tag, cdb_value} <= mem[gnt][rd_ptr[gnt]];
        cdb_fu_idx <= gnt;
      end else begin
        cdb_valid <= 1'b0;
        cdb_tag <= TAG_W'(INVALID_TAG);
        cdb_value <= '0;
      end
    end
  end
endmodule
